// File: rtl/pc_fetch.sv
// Program counter and instruction fetch for the Hack-style CPU: fetches the
// instruction at pc from ROM over req/ack and hands it to the decoder with valid/done.
//
// state   | meaning
// S_IDLE  | just out of reset, first fetch not yet requested
// S_REQ   | rom_req high, waiting for rom_ack
// S_VALID | instr held for the decoder, waiting for exec_done
module pc_fetch #(
  parameter int ADDR_W = 15,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int RET_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_load,
  input  logic               pc_inc,
  input  logic [ADDR_W-1:0]  jmp_target,
  input  logic               exec_done,
  output logic               rom_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [RET_W-1:0]   retired,
  output logic               ctrl_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [RET_W-1:0]    ret_q, ret_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VEC;
      req_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      ret_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ret_d   = ret_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        if (rom_ack) begin
          instr_d = rom_data;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (exec_done) begin
          // neither load nor inc is a jump-control fault; refetch same address
          if (pc_load)     pc_d = jmp_target;
          else if (pc_inc) pc_d = pc_q + 1'b1;
          else             err_d = 1'b1;
          if (ret_q != {RET_W{1'b1}}) ret_d = ret_q + 1'b1;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign rom_req     = req_q;
  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign retired     = ret_q;
  assign ctrl_err    = err_q;

endmodule
